// File: rtl/prog_clk_div.sv
// prog_clk_div: programmable power-of-two clock divider. The selection is
// reloaded only at the end of a full period, so DIV_CLK never glitches.
module prog_clk_div #(
  parameter int SEL_W   = 4,
  parameter int MAX_SEL = 15
) (
  input  logic             DIV_MASTER_CLK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic [SEL_W-1:0] CLK_DIV_SW,
  output logic             DIV_CLK,
  output logic             DIV_STB,
  output logic [SEL_W-1:0] ACTIVE_SEL
);

  localparam int               CNT_W   = (MAX_SEL > 1) ? MAX_SEL : 1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(MAX_SEL);

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] x);
    return (x > SEL_MAX) ? SEL_MAX : x;
  endfunction

  // Last count of a half period, H-1 = 2^sel - 1: the low sel bits set.
  function automatic logic [CNT_W-1:0] half_last(input logic [SEL_W-1:0] sel);
    logic [CNT_W-1:0] m;
    for (int i = 0; i < CNT_W; i++) begin
      m[i] = (i < int'(sel));
    end
    return m;
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clk_p0;
  logic             clk_nxt;
  logic             stb_p0;
  logic             stb_nxt;
  logic [SEL_W-1:0] sel_p0;
  logic [SEL_W-1:0] sel_nxt;
  logic             last;

  // Stage p0: divider state register
  always_ff @(posedge DIV_MASTER_CLK) begin
    if (!RESET_N) begin
      cnt_p0 <= '0;
      clk_p0 <= 1'b0;
      stb_p0 <= 1'b0;
      sel_p0 <= clamp_sel(CLK_DIV_SW);
    end else begin
      cnt_p0 <= cnt_nxt;
      clk_p0 <= clk_nxt;
      stb_p0 <= stb_nxt;
      sel_p0 <= sel_nxt;
    end
  end

  always_comb begin
    last    = (cnt_p0 == half_last(sel_p0));
    cnt_nxt = cnt_p0;
    clk_nxt = clk_p0;
    stb_nxt = 1'b0;
    sel_nxt = sel_p0;
    if (EN) begin
      if (last) begin
        cnt_nxt = '0;
        clk_nxt = ~clk_p0;
        stb_nxt = ~clk_p0;
        // Falling edge closes a full period: the only point a new selection is taken.
        if (clk_p0) begin
          sel_nxt = clamp_sel(CLK_DIV_SW);
        end
      end else begin
        cnt_nxt = cnt_p0 + CNT_W'(1);
      end
    end
  end

  always_comb begin
    DIV_CLK    = clk_p0;
    DIV_STB    = stb_p0;
    ACTIVE_SEL = sel_p0;
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: default build plus a MAX_SEL=5 build driven in parallel,
// scoreboarded every cycle against a countdown model, plus directed timing sequences.
module tb_prog_clk_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] sw;
  logic       div_clk, div_stb, div_clk5, div_stb5;
  logic [3:0] act_sel, act_sel5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stb_cnt = 0;

  logic [11:0] sbq[$];

  logic m_clk[2];
  logic m_stb[2];
  int   m_sel[2];
  int   m_left[2];

  typedef struct {
    logic [3:0] sw;
    int         exp_sel;
    int         exp_sel5;
    int         exp_rise;
    int         exp_rise5;
  } vec_t;

  vec_t vecs[6];

  prog_clk_div dut (
    .DIV_MASTER_CLK(clk),
    .RESET_N       (rst_n),
    .EN            (en),
    .CLK_DIV_SW    (sw),
    .DIV_CLK       (div_clk),
    .DIV_STB       (div_stb),
    .ACTIVE_SEL    (act_sel)
  );

  prog_clk_div #(.SEL_W(4), .MAX_SEL(5)) dut5 (
    .DIV_MASTER_CLK(clk),
    .RESET_N       (rst_n),
    .EN            (en),
    .CLK_DIV_SW    (sw),
    .DIV_CLK       (div_clk5),
    .DIV_STB       (div_stb5),
    .ACTIVE_SEL    (act_sel5)
  );

  initial forever #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int clampv(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  // Countdown model: m_left is the number of enabled edges left in the current phase.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mx;
      mx = (k == 0) ? 15 : 5;
      if (!rst_n) begin
        m_sel[k]  = clampv(int'(sw), mx);
        m_clk[k]  = 1'b0;
        m_stb[k]  = 1'b0;
        m_left[k] = 1 << m_sel[k];
      end else begin
        m_stb[k] = 1'b0;
        if (en) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            if (m_clk[k]) m_sel[k] = clampv(int'(sw), mx);
            m_stb[k]  = ~m_clk[k];
            m_clk[k]  = ~m_clk[k];
            m_left[k] = 1 << m_sel[k];
          end
        end
      end
    end
  endtask

  task automatic tick();
    logic [11:0] got;
    logic [11:0] exp;
    logic [3:0]  s0, s1;
    model_step();
    s0 = m_sel[0][3:0];
    s1 = m_sel[1][3:0];
    sbq.push_back({m_clk[0], m_stb[0], s0, m_clk[1], m_stb[1], s1});
    @(posedge clk);
    #1;
    cyc++;
    if (div_stb === 1'b1) stb_cnt++;
    got = {div_clk, div_stb, act_sel, div_clk5, div_stb5, act_sel5};
    exp = sbq.pop_front();
    check("scoreboard", 32'(got), 32'(exp));
  endtask

  task automatic apply_reset(input logic [3:0] s, input int n);
    rst_n = 1'b0;
    en    = 1'b1;
    sw    = s;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_level(input int which, input logic lvl, input int bound, output int n);
    logic cur;
    n = 0;
    do begin
      tick();
      n++;
      cur = (which == 0) ? div_clk : div_clk5;
    end while (cur !== lvl && n < bound);
  endtask

  initial begin
    int n, r0, r5, bound;

    vecs[0] = '{4'd0,  0,  0, 1,    1};
    vecs[1] = '{4'd2,  2,  2, 4,    4};
    vecs[2] = '{4'd5,  5,  5, 32,   32};
    vecs[3] = '{4'd7,  7,  5, 128,  32};
    vecs[4] = '{4'd10, 10, 5, 1024, 32};
    vecs[5] = '{4'd15, 15, 5, 0,    32};

    rst_n = 1'b0;
    en    = 1'b1;
    sw    = 4'd0;

    for (int v = 0; v < 6; v++) begin
      apply_reset(vecs[v].sw, 2);
      check($sformatf("vec%0d_rst_sel", v), act_sel, vecs[v].exp_sel);
      check($sformatf("vec%0d_rst_sel5", v), act_sel5, vecs[v].exp_sel5);
      check($sformatf("vec%0d_rst_clk", v), div_clk, 0);
      check($sformatf("vec%0d_rst_stb", v), div_stb, 0);
      bound = ((vecs[v].exp_rise > vecs[v].exp_rise5) ? vecs[v].exp_rise : vecs[v].exp_rise5) + 4;
      r0 = 0;
      r5 = 0;
      for (int i = 1; i <= bound; i++) begin
        tick();
        if (r0 == 0 && div_clk === 1'b1) r0 = i;
        if (r5 == 0 && div_clk5 === 1'b1) r5 = i;
      end
      if (vecs[v].exp_rise != 0) check($sformatf("vec%0d_first_rise", v), r0, vecs[v].exp_rise);
      check($sformatf("vec%0d_first_rise5", v), r5, vecs[v].exp_rise5);
    end

    // S=7: rise on 128th edge, period 256, one strobe per period on the rise.
    apply_reset(4'd7, 1);
    wait_level(0, 1'b1, 140, n);
    check("s7_first_rise", n, 128);
    check("s7_stb_at_rise", div_stb, 1);
    stb_cnt = 0;
    wait_level(0, 1'b0, 140, n);
    check("s7_high_len", n, 128);
    wait_level(0, 1'b1, 140, n);
    check("s7_low_len", n, 128);
    check("s7_stb_per_period", stb_cnt, 1);
    check("s7_stb_at_rise2", div_stb, 1);

    // S=0: toggle every cycle, strobe on every high cycle.
    apply_reset(4'd0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("s0_clk_%0d", i), div_clk, (i % 2 == 0) ? 1 : 0);
      check($sformatf("s0_stb_%0d", i), div_stb, (i % 2 == 0) ? 1 : 0);
    end

    // S=3 -> S=1 requested mid high phase: current period completes first.
    apply_reset(4'd3, 1);
    wait_level(0, 1'b1, 20, n);
    check("chg_first_rise", n, 8);
    repeat (3) tick();
    sw = 4'd1;
    tick();
    check("chg_sel_held", act_sel, 3);
    check("chg_clk_held", div_clk, 1);
    wait_level(0, 1'b0, 20, n);
    check("chg_rest_of_high", n, 4);
    check("chg_sel_loaded", act_sel, 1);
    wait_level(0, 1'b1, 20, n);
    check("chg_new_low", n, 2);
    wait_level(0, 1'b0, 20, n);
    check("chg_new_high", n, 2);

    // MAX_SEL=5 build clamps an all-ones request to 5: period 64.
    apply_reset(4'd15, 1);
    check("max5_sel", act_sel5, 5);
    check("max15_sel", act_sel, 15);
    wait_level(1, 1'b1, 80, n);
    check("max5_first_rise", n, 32);
    wait_level(1, 1'b0, 80, n);
    check("max5_high", n, 32);
    wait_level(1, 1'b1, 80, n);
    check("max5_low", n, 32);

    // S=2: hold for 10 cycles in the low phase delays the rise by exactly 10.
    apply_reset(4'd2, 1);
    repeat (2) tick();
    en = 1'b0;
    sw = 4'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold_clk_%0d", i), div_clk, 0);
      check($sformatf("hold_stb_%0d", i), div_stb, 0);
      check($sformatf("hold_sel_%0d", i), act_sel, 2);
    end
    en = 1'b1;
    wait_level(0, 1'b1, 20, n);
    check("hold_resume_rise", n, 2);

    // S=4: one-cycle reset mid high phase restarts the low phase.
    apply_reset(4'd4, 1);
    wait_level(0, 1'b1, 30, n);
    check("rst_mid_first_rise", n, 16);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_clk", div_clk, 0);
    check("rst_mid_stb", div_stb, 0);
    check("rst_mid_sel", act_sel, 4);
    rst_n = 1'b1;
    wait_level(0, 1'b1, 30, n);
    check("rst_mid_rise_after", n, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
